fp_round_pack: RTL and testbench

//  Back end of the rounder: takes the unrounded significand/exponent pair the rounder

---
 rtl/fp_round_pack_if.sv | 33 +++
 rtl/fp_round_pack.sv | 256 +++++++++++++++++++++++++
 tb/tb_fp_round_pack.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_round_pack_if.sv
// fp_round_pack_if: operand and result handshake bundle for fp_round_pack.
//   in_valid/in_ready : operand handshake (s, fr, er, db, rm)
//   out_valid/out_ready : result handshake (result, ovf, unf, inx)
//   master = operand producer / result consumer, slave = the rounder back end.
interface fp_round_pack_if;
    localparam int unsigned FW = 57;
    localparam int unsigned EW = 13;
    localparam int unsigned RW = 64;

    logic          in_valid;
    logic          in_ready;
    logic          s;
    logic [FW-1:0] fr;
    logic [EW-1:0] er;
    logic          db;
    logic [1:0]    rm;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] result;
    logic          ovf;
    logic          unf;
    logic          inx;

    modport master (
        output in_valid, s, fr, er, db, rm, out_ready,
        input  in_ready, out_valid, result, ovf, unf, inx
    );

    modport slave (
        input  in_valid, s, fr, er, db, rm, out_ready,
        output in_ready, out_valid, result, ovf, unf, inx
    );
endinterface

// File: rtl/fp_round_pack.sv
// fp_round_pack: normalize, denormal-clamp, IEEE-round and pack an unrounded
// significand/exponent pair (value = fr[56:55].fr[54:0] * 2^er) into single or
// double format, with OVF/UNF/INX flags.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fp_round_pack_if.slave (operand in, packed result + flags out)
module fp_round_pack (
    input  logic           clk,
    input  logic           rst,
    fp_round_pack_if.slave bus
);
    localparam int unsigned FW = 57;
    localparam int unsigned EW = 13;
    localparam int unsigned XW = 15;
    localparam int unsigned SW = 56;
    localparam int unsigned RW = 64;

    localparam logic signed [XW-1:0] EMIN_D = -15'sd1022;
    localparam logic signed [XW-1:0] EMIN_S = -15'sd126;
    localparam logic signed [XW-1:0] EMAX_D = 15'sd1023;
    localparam logic signed [XW-1:0] EMAX_S = 15'sd127;
    localparam logic signed [XW-1:0] BIAS_D = 15'sd1023;
    localparam logic signed [XW-1:0] BIAS_S = 15'sd127;

    typedef enum logic [1:0] {IDLE, NORM, RND, DONE} state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic                  s_q, s_d, db_q, db_d;
    logic [1:0]            rm_q, rm_d;
    logic [FW-1:0]         fr_q, fr_d;
    logic [EW-1:0]         er_q, er_d;
    logic [SW-1:0]         sig_q, sig_d;
    logic signed [XW-1:0]  e_q, e_d;
    logic                  st_q, st_d, tiny_q, tiny_d, zero_q, zero_d;
    logic [RW-1:0]         result_q, result_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

    // Leading-zero count of a 57-bit vector (57 when all zero).
    function automatic logic [5:0] lzc(input logic [FW-1:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd57;
        found = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 6'(FW - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Normalization: hidden bit lands at sig[55]; tiny values clamp to emin.
    logic [SW-1:0]        sig_n;
    logic signed [XW-1:0] e_n, emin;
    logic                 st_n, tiny_n, zero_n;
    logic [5:0]           lz, lzm1, dsh_sat;
    logic [FW-1:0]        wide, mask;
    logic [XW-1:0]        dsh;

    always_comb begin : norm_c
        wide    = '0;
        mask    = '0;
        st_n    = 1'b0;
        tiny_n  = 1'b0;
        zero_n  = 1'b0;
        lz      = lzc(fr_q);
        lzm1    = '0;
        dsh     = '0;
        dsh_sat = '0;
        emin    = db_q ? EMIN_D : EMIN_S;
        e_n     = {{(XW-EW){er_q[EW-1]}}, er_q};
        if (fr_q == '0) begin
            zero_n = 1'b1;
        end else if (fr_q[FW-1]) begin
            wide = fr_q >> 1;
            st_n = fr_q[0];
            e_n  = e_n + 15'sd1;
        end else begin
            lzm1 = lz - 6'd1;
            wide = fr_q << lzm1;
            e_n  = e_n - $signed({9'd0, lzm1});
        end
        // Shifts of 57 or more flush every bit into sticky.
        if (!zero_n && (e_n < emin)) begin
            dsh     = emin - e_n;
            dsh_sat = (dsh > 15'd58) ? 6'd58 : dsh[5:0];
            mask    = ~({FW{1'b1}} << dsh_sat);
            st_n    = st_n | (|(wide & mask));
            wide    = wide >> dsh_sat;
            e_n     = emin;
            tiny_n  = 1'b1;
        end
        sig_n = wide[SW-1:0];
    end

    // Rounding and packing of the normalized operand.
    logic [52:0]          mant;
    logic [53:0]          mr;
    logic                 guard, sticky, inexact, inc, carry, hidden, to_inf;
    logic signed [XW-1:0] e_r, emax, bias;
    logic [10:0]          exp_f;
    logic [RW-1:0]        res;
    logic                 ovf_r, unf_r, inx_r;

    always_comb begin : rnd_c
        emax = db_q ? EMAX_D : EMAX_S;
        bias = db_q ? BIAS_D : BIAS_S;
        if (db_q) begin
            mant   = sig_q[55:3];
            guard  = sig_q[2];
            sticky = st_q | (|sig_q[1:0]);
        end else begin
            mant   = {29'd0, sig_q[55:32]};
            guard  = sig_q[31];
            sticky = st_q | (|sig_q[30:0]);
        end
        inexact = guard | sticky;
        case (rm_q)
            2'b00:   inc = guard & (sticky | mant[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = ~s_q & inexact;
            default: inc = s_q & inexact;
        endcase
        mr    = {1'b0, mant} + 54'(inc);
        carry = db_q ? mr[53] : mr[24];
        e_r   = e_q;
        if (carry) begin
            mr  = mr >> 1;
            e_r = e_q + 15'sd1;
        end
        // A denormal that rounds up into the hidden bit gets exp field emin+bias = 1.
        hidden = db_q ? mr[52] : mr[23];
        exp_f  = hidden ? 11'(e_r + bias) : 11'd0;
        to_inf = (rm_q == 2'b00) | ((rm_q == 2'b10) & ~s_q) | ((rm_q == 2'b11) & s_q);
        ovf_r  = 1'b0;
        inx_r  = inexact;
        unf_r  = tiny_q & inexact;
        if (zero_q) begin
            res   = db_q ? {s_q, 63'd0} : {32'd0, s_q, 31'd0};
            inx_r = 1'b0;
            unf_r = 1'b0;
        end else if (e_r > emax) begin
            ovf_r = 1'b1;
            inx_r = 1'b1;
            if (db_q) begin
                res = to_inf ? {s_q, 11'h7FF, 52'd0} : {s_q, 11'h7FE, {52{1'b1}}};
            end else begin
                res = to_inf ? {32'd0, s_q, 8'hFF, 23'd0} : {32'd0, s_q, 8'hFE, {23{1'b1}}};
            end
        end else if (db_q) begin
            res = {s_q, exp_f, mr[51:0]};
        end else begin
            res = {32'd0, s_q, exp_f[7:0], mr[22:0]};
        end
    end

    // FSM next state, operand capture and stage registers.
    always_comb begin : fsm_c
        state_d  = state_q;
        s_d      = s_q;
        fr_d     = fr_q;
        er_d     = er_q;
        db_d     = db_q;
        rm_d     = rm_q;
        sig_d    = sig_q;
        e_d      = e_q;
        st_d     = st_q;
        tiny_d   = tiny_q;
        zero_d   = zero_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        inx_d    = inx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    s_d     = bus.s;
                    fr_d    = bus.fr;
                    er_d    = bus.er;
                    db_d    = bus.db;
                    rm_d    = bus.rm;
                    state_d = NORM;
                end
            end
            NORM: begin
                sig_d   = sig_n;
                e_d     = e_n;
                st_d    = st_n;
                tiny_d  = tiny_n;
                zero_d  = zero_n;
                state_d = RND;
            end
            RND: begin
                result_d = res;
                ovf_d    = ovf_r;
                unf_d    = unf_r;
                inx_d    = inx_r;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= 1'b0;
            fr_q        <= '0;
            er_q        <= '0;
            db_q        <= 1'b0;
            rm_q        <= '0;
            sig_q       <= '0;
            e_q         <= '0;
            st_q        <= 1'b0;
            tiny_q      <= 1'b0;
            zero_q      <= 1'b0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            fr_q        <= fr_d;
            er_q        <= er_d;
            db_q        <= db_d;
            rm_q        <= rm_d;
            sig_q       <= sig_d;
            e_q         <= e_d;
            st_q        <= st_d;
            tiny_q      <= tiny_d;
            zero_q      <= zero_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign bus.inx       = inx_q;
endmodule

// File: tb/tb_fp_round_pack.sv
// tb_fp_round_pack: directed vectors with literal expectations plus a
// rational-arithmetic reference model checked every cycle out_valid is high.
module tb_fp_round_pack;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [66:0] exp_q[$];

    fp_round_pack_if bus();

    fp_round_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: value = fr * 2^(er-55); quantize to the format grid at the
    // (clamped) exponent and round on the exact remainder. Returns {ovf,unf,inx,result}.
    function automatic logic [66:0] model(input logic s, input logic [56:0] fr, input int er,
                                          input logic db, input logic [1:0] rm);
        int p, emax, emin, bias, pos, e_unb, e_eff, q, d, k, e_fin;
        logic tiny, gt, eq, nz, inc, ovf, unf, inx, to_inf;
        logic [127:0] m, rem, half, frw, frac;
        longint field;
        logic [63:0] res;
        p    = db ? 53 : 24;
        emax = db ? 1023 : 127;
        emin = db ? -1022 : -126;
        bias = db ? 1023 : 127;
        if (fr == '0) return {3'b000, (db ? {s, 63'd0} : {32'd0, s, 31'd0})};
        pos = 0;
        for (int i = 0; i < 57; i++) if (fr[i]) pos = i;
        e_unb = er + pos - 55;
        tiny  = (e_unb < emin);
        e_eff = tiny ? emin : e_unb;
        q     = e_eff - (p - 1);
        d     = er - 55 - q;
        frw   = 128'(fr);
        rem   = '0;
        half  = '0;
        gt = 1'b0; eq = 1'b0; nz = 1'b0;
        if (d >= 0) begin
            m = frw << d;
        end else begin
            k = -d;
            if (k > 100) begin
                m  = '0;
                nz = 1'b1;
            end else begin
                m    = frw >> k;
                rem  = frw & ((128'd1 << k) - 128'd1);
                half = 128'd1 << (k - 1);
                gt   = rem > half;
                eq   = rem == half;
                nz   = rem != '0;
            end
        end
        case (rm)
            2'b00:   inc = gt | (eq & m[0]);
            2'b01:   inc = 1'b0;
            2'b10:   inc = !s && nz;
            default: inc = s && nz;
        endcase
        m     = m + 128'(inc);
        e_fin = e_eff;
        if (m == (128'd1 << p)) begin
            m     = 128'd1 << (p - 1);
            e_fin = e_fin + 1;
        end
        inx = nz;
        unf = tiny & nz;
        ovf = 1'b0;
        if (e_fin > emax) begin
            ovf    = 1'b1;
            inx    = 1'b1;
            to_inf = (rm == 2'b00) || (rm == 2'b10 && !s) || (rm == 2'b11 && s);
            if (db) res = to_inf ? {s, 11'h7FF, 52'd0} : {s, 63'h7FEFFFFFFFFFFFFF};
            else    res = to_inf ? {32'd0, s, 31'h7F800000} : {32'd0, s, 31'h7F7FFFFF};
        end else begin
            if (m >= (128'd1 << (p - 1))) begin
                field = longint'(e_fin + bias);
                frac  = m - (128'd1 << (p - 1));
            end else begin
                field = 0;
                frac  = m;
            end
            res = db ? {s, 11'(field), 52'(frac)} : {32'd0, s, 8'(field), 23'(frac)};
        end
        return {ovf, unf, inx, res};
    endfunction

    task automatic chk(input string nm, input logic [66:0] act, input logic [66:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Per-cycle compare against the model while a result is presented.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cmp: out_valid with no pending operand, got %h", bus.result);
            end else if ({bus.ovf, bus.unf, bus.inx, bus.result} !== exp_q[0]) begin
                errors++;
                $display("FAIL cmp: got %h required %h",
                         {bus.ovf, bus.unf, bus.inx, bus.result}, exp_q[0]);
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    task automatic recover();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic do_op(input string nm, input logic s, input logic [56:0] fr, input int er,
                         input logic db, input logic [1:0] rm, input logic [66:0] lit,
                         input bit use_lit, input int hold);
        logic [66:0] m;
        int n;
        bit ok;
        m = model(s, fr, er, db, rm);
        if (use_lit) chk({nm, "_model"}, m, lit);
        exp_q.push_back(m);
        bus.s = s; bus.fr = fr; bus.er = 13'(er); bus.db = db; bus.rm = rm;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            if (bus.in_ready) ok = 1'b1;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!ok) begin
            chk_int({nm, "_accept_timeout"}, 0, 1);
            recover();
            return;
        end
        // The accept edge is edge 1.
        n = 1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (bus.out_valid) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!ok) begin
            chk_int({nm, "_out_valid_timeout"}, 0, 1);
            recover();
            return;
        end
        chk_int({nm, "_latency"}, n, 3);
        if (use_lit) chk({nm, "_dut"}, {bus.ovf, bus.unf, bus.inx, bus.result}, lit);
        // Stall the consumer while offering a different operand that must be ignored.
        for (int i = 0; i < hold; i++) begin
            bus.fr = ~fr; bus.s = ~s; bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk_int({nm, "_hold_in_ready"}, int'(bus.in_ready), 0);
            chk_int({nm, "_hold_out_valid"}, int'(bus.out_valid), 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk_int({nm, "_out_valid_drop"}, int'(bus.out_valid), 0);
        chk_int({nm, "_in_ready_back"}, int'(bus.in_ready), 1);
    endtask

    localparam logic [56:0] ONE55 = 57'd1 << 55;
    localparam logic [56:0] ONE56 = 57'd1 << 56;
    localparam logic [56:0] TIE31 = (57'd1 << 55) | (57'd1 << 31);
    localparam logic [56:0] ONES31 = ((57'd1 << 56) - 57'd1) & ~((57'd1 << 31) - 57'd1);

    initial begin
        logic [56:0] rfr;
        logic        rs, rdb;
        logic [1:0]  rrm;
        int          rer;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.s = 1'b0; bus.fr = '0; bus.er = '0; bus.db = 1'b0; bus.rm = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_int("rst_in_ready", int'(bus.in_ready), 1);
        chk_int("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_result", {bus.ovf, bus.unf, bus.inx, bus.result}, 67'd0);

        do_op("one_dbl",   1'b0, ONE55, 0,     1'b1, 2'b00, {3'b000, 64'h3FF0000000000000}, 1, 0);
        do_op("ovf_rne",   1'b0, ONE56, 127,   1'b0, 2'b00, {3'b101, 64'h000000007F800000}, 1, 0);
        do_op("ovf_rz",    1'b0, ONE56, 127,   1'b0, 2'b01, {3'b101, 64'h000000007F7FFFFF}, 1, 0);
        do_op("tie_rne",   1'b0, TIE31, 0,     1'b0, 2'b00, {3'b001, 64'h000000003F800000}, 1, 0);
        do_op("tie_ru",    1'b0, TIE31, 0,     1'b0, 2'b10, {3'b001, 64'h000000003F800001}, 1, 0);
        do_op("dn_min",    1'b0, ONE55, -1074, 1'b1, 2'b00, {3'b000, 64'h0000000000000001}, 1, 0);
        do_op("dn_half",   1'b0, ONE55, -1075, 1'b1, 2'b00, {3'b011, 64'h0000000000000000}, 1, 0);
        do_op("dn_half_ru",1'b0, ONE55, -1075, 1'b1, 2'b10, {3'b011, 64'h0000000000000001}, 1, 0);
        do_op("neg_zero",  1'b1, 57'd0, 0,     1'b1, 2'b00, {3'b000, 64'h8000000000000000}, 1, 0);
        do_op("lz56",      1'b0, 57'd1, 55,    1'b1, 2'b00, {3'b000, 64'h3FF0000000000000}, 1, 5);
        do_op("ovf_rd_neg",1'b1, ONE55, 1024,  1'b1, 2'b11, {3'b101, 64'hFFF0000000000000}, 1, 0);
        do_op("ovf_ru_neg",1'b1, ONE55, 1024,  1'b1, 2'b10, {3'b101, 64'hFFEFFFFFFFFFFFFF}, 1, 0);
        do_op("carry_sgl", 1'b0, ONES31, 0,    1'b0, 2'b00, {3'b001, 64'h0000000040000000}, 1, 0);
        do_op("dn_to_norm",1'b0, ONES31, -127, 1'b0, 2'b00, {3'b011, 64'h0000000000800000}, 1, 0);
        do_op("sgl_min",   1'b0, ONE55, -149,  1'b0, 2'b00, {3'b000, 64'h0000000000000001}, 1, 2);
        do_op("rd_pos",    1'b0, ONE55 | 57'd1, 0, 1'b1, 2'b11, {3'b001, 64'h3FF0000000000000}, 1, 0);
        do_op("rd_neg",    1'b1, ONE55 | 57'd1, 0, 1'b1, 2'b11, {3'b001, 64'hBFF0000000000001}, 1, 0);

        // Reset while in NORM drops the captured operand.
        bus.s = 1'b0; bus.fr = ONE55; bus.er = '0; bus.db = 1'b1; bus.rm = 2'b00;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk_int("rst_norm_out_valid", int'(bus.out_valid), 0);
        chk_int("rst_norm_in_ready", int'(bus.in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk_int("rst_norm_dropped", int'(bus.out_valid), 0);
        end

        for (int i = 0; i < 24; i++) begin
            rs  = 1'($urandom);
            rdb = 1'($urandom);
            rrm = 2'($urandom);
            rfr = 57'({$urandom, $urandom});
            if (i % 4 == 0) rfr = rfr >> $urandom_range(50);
            rer = rdb ? (int'($urandom_range(2400)) - 1200) : (int'($urandom_range(360)) - 180);
            do_op("rand", rs, rfr, rer, rdb, rrm, 67'd0, 0, i % 3);
        end

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
